wave_synth: RTL and testbench

WAVE_SYNTH -- requirements
Module: wave_synth

---
 rtl/wave_synth_if.sv | 26 ++
 rtl/wave_synth.sv | 152 +++++++++++++++
 tb/tb_wave_synth.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/wave_synth_if.sv
// rtl/wave_synth_if.sv - control and sample bus between a driver and wave_synth
interface wave_synth_if #(
   parameter int OUT_W   = 8,
   parameter int PHASE_W = 16
);
   logic               en;
   logic               tick;
   logic               sync;
   logic [PHASE_W-1:0] freq_word;
   logic [1:0]         mode;
   logic [7:0]         amp;
   logic [OUT_W-1:0]   pos_out;
   logic [OUT_W-1:0]   neg_out;
   logic               sample_valid;
   logic               cycle_start;

   modport master (
      output en, tick, sync, freq_word, mode, amp,
      input  pos_out, neg_out, sample_valid, cycle_start
   );

   modport slave (
      input  en, tick, sync, freq_word, mode, amp,
      output pos_out, neg_out, sample_valid, cycle_start
   );
endinterface

// File: rtl/wave_synth.sv
// rtl/wave_synth.sv - phase-accumulator waveform synthesizer with quarter-wave sine ROM and amplitude scaling
module wave_synth #(
   parameter int OUT_W   = 8,
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   wave_synth_if.slave bus
);
   localparam int LUT_N = 1 << LUT_AW;

   // Elaboration-time sine; the series is exact enough over [0, pi/2] for correct rounding.
   function automatic logic [OUT_W-1:0] sine_entry(input int i);
      real x;
      real term;
      real acc;
      real full;
      x    = 3.14159265358979323846 * real'(i) / real'(2 * LUT_N);
      term = x;
      acc  = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      full = real'((1 << OUT_W) - 1);
      return OUT_W'($rtoi(acc * full + 0.5));
   endfunction

   logic [OUT_W-1:0] sine_rom [0:LUT_N];

   for (genvar g = 0; g <= LUT_N; g++) begin : g_rom
      localparam logic [OUT_W-1:0] ENTRY = sine_entry(g);
      assign sine_rom[g] = ENTRY;
   end

   logic [PHASE_W-1:0] phase;
   logic [PHASE_W:0]   phase_sum;
   logic               launch;

   logic               s1_valid;
   logic               s1_wrap;
   logic [1:0]         s1_mode;
   logic [7:0]         s1_amp;

   logic               s2_valid;
   logic               s2_wrap;
   logic               s2_sign;
   logic [OUT_W-1:0]   s2_mag;
   logic [7:0]         s2_amp;

   logic [OUT_W-1:0]   pos_q;
   logic [OUT_W-1:0]   neg_q;
   logic               valid_q;
   logic               start_q;

   logic [OUT_W-1:0]   h;
   logic [OUT_W-1:0]   tri_mag;
   logic [OUT_W-1:0]   mag;
   logic               q;
   logic [LUT_AW-1:0]  idx;
   logic [LUT_AW:0]    lut_addr;

   logic [OUT_W+7:0]   prod;
   logic [OUT_W-1:0]   scaled;

   assign phase_sum = {1'b0, phase} + {1'b0, bus.freq_word};
   assign launch    = bus.en & bus.tick & ~bus.sync;

   // Stage 0: accumulate phase and capture the per-sample controls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase    <= '0;
         s1_valid <= 1'b0;
         s1_wrap  <= 1'b0;
         s1_mode  <= 2'd0;
         s1_amp   <= 8'd0;
      end else begin
         if (bus.sync) begin
            phase <= '0;
         end else if (launch) begin
            phase <= phase_sum[PHASE_W-1:0];
         end
         s1_valid <= launch;
         if (launch) begin
            s1_wrap <= phase_sum[PHASE_W];
            s1_mode <= bus.mode;
            s1_amp  <= bus.amp;
         end
      end
   end

   always_comb begin
      h        = phase[PHASE_W-2 -: OUT_W];
      q        = phase[PHASE_W-2];
      idx      = phase[PHASE_W-3 -: LUT_AW];
      // Second quadrant mirrors the table, hence the extra entry at 2^LUT_AW.
      lut_addr = q ? ((LUT_AW+1)'(LUT_N) - {1'b0, idx}) : {1'b0, idx};
      tri_mag  = h[OUT_W-1] ? ~{h[OUT_W-2:0], 1'b0} : {h[OUT_W-2:0], 1'b0};
      mag      = '0;
      case (s1_mode)
         2'd0:    mag = sine_rom[lut_addr];
         2'd1:    mag = '1;
         2'd2:    mag = tri_mag;
         default: mag = h;
      endcase
   end

   // Stage 1: magnitude and sign from the phase written by the launching edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_wrap  <= 1'b0;
         s2_sign  <= 1'b0;
         s2_mag   <= '0;
         s2_amp   <= 8'd0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_wrap <= s1_wrap;
            s2_sign <= phase[PHASE_W-1];
            s2_mag  <= mag;
            s2_amp  <= s1_amp;
         end
      end
   end

   assign prod   = (OUT_W+8)'(s2_mag) * (OUT_W+8)'({1'b0, s2_amp} + 9'd1);
   assign scaled = OUT_W'(prod >> 8);

   // Stage 2: scale and split into half-wave outputs, held between samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_q   <= '0;
         neg_q   <= '0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         valid_q <= s2_valid;
         start_q <= s2_valid & s2_wrap;
         if (s2_valid) begin
            pos_q <= s2_sign ? '0 : scaled;
            neg_q <= s2_sign ? scaled : '0;
         end
      end
   end

   assign bus.pos_out      = pos_q;
   assign bus.neg_out      = neg_q;
   assign bus.sample_valid = valid_q;
   assign bus.cycle_start  = start_q;
endmodule

// File: tb/tb_wave_synth.sv
// tb/tb_wave_synth.sv - table-driven self-checking bench for wave_synth
module tb_wave_synth;
   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   wave_synth_if #(.OUT_W(8), .PHASE_W(16)) bus ();

   wave_synth #(.OUT_W(8), .PHASE_W(16), .LUT_AW(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic        sy;
      logic [1:0]  mode;
      logic [7:0]  amp;
      logic [15:0] freq;
      logic [7:0]  pos;
      logic [7:0]  neg;
      logic        cs;
      logic        v;
   } vec_t;

   vec_t vq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input int sy, input int mode, input int amp, input int freq,
                      input int pos, input int neg, input int cs, input int v);
      vec_t e;
      e.sy   = 1'(sy);
      e.mode = 2'(mode);
      e.amp  = 8'(amp);
      e.freq = 16'(freq);
      e.pos  = 8'(pos);
      e.neg  = 8'(neg);
      e.cs   = 1'(cs);
      e.v    = 1'(v);
      vq.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int pos, input int neg, input int sv, input int cs);
      check({tag, " pos"}, 32'(bus.pos_out), 32'(pos));
      check({tag, " neg"}, 32'(bus.neg_out), 32'(neg));
      check({tag, " valid"}, 32'(bus.sample_valid), 32'(sv));
      check({tag, " cstart"}, 32'(bus.cycle_start), 32'(cs));
   endtask

   initial begin
      int n;
      // sine, amp 255, quarter-period steps, twice round
      for (int r = 0; r < 2; r++) begin
         add(0, 0, 255, 'h4000, 255, 0,   0, 1);
         add(0, 0, 255, 'h4000, 0,   0,   0, 1);
         add(0, 0, 255, 'h4000, 0,   255, 0, 1);
         add(0, 0, 255, 'h4000, 0,   0,   1, 1);
      end
      // square, amp 127: 255*128>>8 = 127
      for (int r = 0; r < 2; r++) begin
         add(0, 1, 127, 'h8000, 0,   127, 0, 1);
         add(0, 1, 127, 'h8000, 127, 0,   1, 1);
      end
      // triangle, amp 255
      add(0, 2, 255, 'h2000, 128, 0,   0, 1);
      add(0, 2, 255, 'h2000, 255, 0,   0, 1);
      add(0, 2, 255, 'h2000, 127, 0,   0, 1);
      add(0, 2, 255, 'h2000, 0,   0,   0, 1);
      add(0, 2, 255, 'h2000, 0,   128, 0, 1);
      add(0, 2, 255, 'h2000, 0,   255, 0, 1);
      add(0, 2, 255, 'h2000, 0,   127, 0, 1);
      add(0, 2, 255, 'h2000, 0,   0,   1, 1);
      // sawtooth, amp 255, phases 3000..F000 then wrap to 2000
      add(0, 3, 255, 'h3000, 96,  0,   0, 1);
      add(0, 3, 255, 'h3000, 192, 0,   0, 1);
      add(0, 3, 255, 'h3000, 0,   32,  0, 1);
      add(0, 3, 255, 'h3000, 0,   128, 0, 1);
      add(0, 3, 255, 'h3000, 0,   224, 0, 1);
      add(0, 3, 255, 'h3000, 64,  0,   1, 1);
      // sync with tick: no sample, outputs hold, phase to 0
      add(1, 3, 255, 'h3000, 64,  0,   0, 0);
      add(0, 3, 127, 'h4000, 64,  0,   0, 1);
      add(0, 3, 127, 'h0000, 64,  0,   0, 1);
      // sine ROM interior entries at 0x5000 (addr 48) and 0x7000 (addr 16)
      add(0, 0, 255, 'h1000, 236, 0,   0, 1);
      add(0, 0, 255, 'h2000, 98,  0,   0, 1);
      add(1, 0, 255, 'h2000, 98,  0,   0, 0);
      // backward phase steps
      add(0, 3, 255, 'hFFFF, 0,   255, 0, 1);
      add(0, 3, 255, 'hFFFF, 0,   255, 1, 1);
      add(0, 3, 255, 'hFFFF, 0,   255, 1, 1);
      add(1, 3, 255, 'hFFFF, 0,   255, 0, 0);
      add(0, 3, 255, 'hFFFF, 0,   255, 0, 1);
      add(0, 3, 255, 'hFFFF, 0,   255, 1, 1);

      reset_n       = 1'b0;
      bus.en        = 1'b1;
      bus.tick      = 1'b0;
      bus.sync      = 1'b0;
      bus.freq_word = '0;
      bus.mode      = 2'd0;
      bus.amp       = 8'd0;
      step();
      step();
      check_out("reset", 0, 0, 0, 0);
      reset_n = 1'b1;
      step();

      n = vq.size();
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            bus.sync      = vq[i].sy;
            bus.tick      = 1'b1;
            bus.mode      = vq[i].mode;
            bus.amp       = vq[i].amp;
            bus.freq_word = vq[i].freq;
         end else begin
            bus.sync = 1'b0;
            bus.tick = 1'b0;
         end
         step();
         if (i >= 2) begin
            check_out($sformatf("row%0d", i - 2), int'(vq[i-2].pos), int'(vq[i-2].neg),
                      int'(vq[i-2].v), int'(vq[i-2].cs));
         end else begin
            check($sformatf("latency%0d valid", i), 32'(bus.sample_valid), 32'd0);
         end
      end

      // en low: ticks ignored, outputs hold, phase stays at 0xFFFE
      bus.en        = 1'b0;
      bus.tick      = 1'b1;
      bus.sync      = 1'b0;
      bus.mode      = 2'd3;
      bus.amp       = 8'd255;
      bus.freq_word = 16'h1000;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("en_low%0d", i), 0, 255, 0, 0);
      end
      // one enabled tick, then en low again must not flush it: 0xFFFE+0x1000 = 0x0FFE wraps
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      step();
      check("en_flush e1 valid", 32'(bus.sample_valid), 32'd0);
      step();
      check_out("en_flush", 31, 0, 1, 1);
      step();
      check_out("en_hold", 31, 0, 0, 0);

      // reset while a sample sits in the pipeline
      bus.en   = 1'b1;
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
      reset_n = 1'b0;
      #1;
      check_out("async_reset", 0, 0, 0, 0);
      #5;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post_reset%0d valid", i), 32'(bus.sample_valid), 32'd0);
      end
      // first tick after reset starts from phase 0
      bus.mode      = 2'd3;
      bus.amp       = 8'd255;
      bus.freq_word = 16'h4000;
      bus.tick      = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
      step();
      check_out("first_after_reset", 128, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
